// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sweeps the select of an attached N-input mux through a run
// of consecutive indices (with wrap-around) and streams each selected word
// out through a registered valid/ready stage.
module mux_scan_ctrl #(
    parameter int N     = 16,
    parameter int SW    = 6,
    parameter int DEPTH = 40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] first,
    input  logic [SW:0]   count,
    output logic [SW-1:0] slc,
    input  logic [N-1:0]  mux_out,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Depth constants are kept one bit wider than the select so that a fully
    // populated mux (DEPTH = 2^SW) still compares correctly.
    localparam logic [SW:0] DEPTH_W  = (SW+1)'(DEPTH);
    localparam logic [SW:0] LAST_IDX = (SW+1)'(DEPTH - 1);
    localparam logic [SW:0] ONE_W    = (SW+1)'(1);

    state_t        state_q;
    logic [SW-1:0] slc_q;
    logic [SW:0]   remaining_q;
    logic [N-1:0]  outData_q;
    logic          outValid_q;
    logic          outLast_q;
    logic          busy_q;
    logic          done_q;

    logic [SW:0]   countClamped_d;
    logic [SW-1:0] firstClamped_d;
    logic [SW-1:0] slcNext_d;
    logic          accept_d;
    logic          load_d;

    // Command clamping, select wrap and handshake decode for the state machine.
    always_comb begin
        countClamped_d = (count > DEPTH_W) ? DEPTH_W : count;
        firstClamped_d = ({1'b0, first} >= DEPTH_W) ? '0 : first;
        slcNext_d      = ({1'b0, slc_q} == LAST_IDX) ? '0 : slc_q + 1'b1;
        accept_d       = outValid_q & out_ready;
        load_d         = (state_q == RUN) && (remaining_q != '0) && (!outValid_q || out_ready);
    end

    // Sequencer: accepts a run in IDLE, loads one word per handshake slot in
    // RUN, then waits in DRAIN for the final word to be taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slc_q       <= '0;
            remaining_q <= '0;
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        remaining_q <= countClamped_d;
                        slc_q       <= firstClamped_d;
                        if (countClamped_d != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_d) begin
                        outData_q   <= mux_out;
                        outValid_q  <= 1'b1;
                        outLast_q   <= (remaining_q == ONE_W);
                        slc_q       <= slcNext_d;
                        remaining_q <= remaining_q - ONE_W;
                        if (remaining_q == ONE_W) begin
                            state_q <= DRAIN;
                        end
                    end else if (accept_d) begin
                        outValid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (accept_d) begin
                        outValid_q <= 1'b0;
                        outLast_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign slc       = slc_q;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that drives the select input of one muxNin instance (mux8in/16in/32in/40in/64in) and consumes its combinational output. On a start command it sweeps the select through a run of consecutive input indices, with wrap-around. It registers each selected word into a valid/ready output stage that feeds the PE/accumulator array. It is the control stage that turns a wide parallel operand bank into a serial operand stream.

Parameters:
N, 16, data width; must equal the N of the attached mux.
SW, 6, select width; must equal the slc width of the attached mux.
DEPTH, 40, number of mux inputs in use; legal range 2..2^SW.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst  input  1  synchronous active-high reset.
start  input  1  one-cycle command pulse; accepted only in IDLE.
first  input  SW  first index of the run; sampled when start is accepted.
count  input  SW+1  number of words in the run; sampled when start is accepted.
slc  output  SW  registered select; drives the mux slc port.
mux_out  input  N  combinational output of the attached mux.
out_data  output  N  registered selected word.
out_valid  output  1  out_data is valid.
out_last  output  1  marks the final word of the run; valid only while out_valid=1.
out_ready  input  1  downstream accepts out_data when out_valid & out_ready.
busy  output  1  high in RUN and DRAIN.
done  output  1  one-cycle pulse when a run completes.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: slc=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, state=IDLE, remaining=0.
- A reset asserted mid-run aborts the run. No done pulse is issued and all outputs return to their reset values on the next edge.
- State IDLE:
  - start=1 latches remaining=min(count,DEPTH).
  - It also sets slc=first, or slc=0 if first>=DEPTH.
  - If the clamped count is nonzero, go to RUN and set busy=1.
  - If count=0, stay in IDLE, pulse done for one cycle, and emit no beats.
- start outside IDLE is ignored, including any start in the same cycle that done is pulsed.
- Load condition in RUN: load = (remaining!=0) & (!out_valid | out_ready).
- On each load:
  - out_data <= mux_out, i.e. the word selected by the current slc.
  - out_valid <= 1.
  - out_last <= (remaining==1).
  - slc <= (slc==DEPTH-1) ? 0 : slc+1.
  - remaining <= remaining-1.
- When a load sets remaining to 0, go to DRAIN.
- State DRAIN:
  - Hold out_data, out_valid and out_last until the beat is accepted (out_valid & out_ready).
  - On acceptance: out_valid <= 0, out_last <= 0, busy <= 0, done <= 1 for one cycle, go to IDLE.
- Acceptance without a load in RUN (remaining=0 cannot occur there) clears out_valid.
- Acceptance with a load in the same cycle replaces the word with no bubble.
- While out_valid=1 & out_ready=0:
  - out_data, out_last and slc are frozen.
  - mux_out is ignored.
- slc holds its last value in IDLE.
- Latency:
  - start accepted at edge t gives slc=first after t.
  - The first word is valid after edge t+1.
  - With out_ready tied high, throughput is one word per cycle.
  - A run of C words asserts done after edge t+C+1.
- Wrap-around: a run that crosses index DEPTH-1 continues at 0. With count=DEPTH, every input is visited exactly once.
- Width rules:
  - remaining is SW+1 bits.
  - The DEPTH comparison uses SW+1-bit arithmetic, so DEPTH=2^SW is legal.
- Protocol invariant: out_data and out_last are stable while out_valid=1 and no acceptance has occurred.

Test Plan:
- DEPTH=40, mux bank in_k=16'h0100+k, out_ready=1; start with first=3, count=5 -> out_data 0x0103..0x0107 on 5 consecutive cycles; out_last only on 0x0107; done one cycle after the last beat; busy high for 6 cycles.
- Wrap-around: first=38, count=4 -> beats 0x0126, 0x0127, 0x0100, 0x0101; slc returns to 0 after index 39.
- Backpressure: first=0, count=3, out_ready low for 3 cycles after the first valid -> 0x0100 is held stable and slc stays at 1. Release ready -> 0x0101 and 0x0102 follow with no bubble; no beat is dropped or duplicated.
- Boundary commands:
  - count=0 -> done pulse the next cycle, out_valid never rises.
  - count=50 -> clamped to 40 beats.
  - first=45 -> run starts at index 0.
- Ignored start: a second start mid-run with first=10 has no effect; the original sequence completes unchanged and exactly one done is produced.
- Reset mid-run: rst high for 1 cycle after the 2nd beat -> next edge gives out_valid=0, busy=0, slc=0, no done. A fresh start then runs normally.
